// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives a 1-cycle-latency ROM from a registered fetch pointer
// and fills the IF/ID register, parking the in-flight word in a skid slot while decode stalls.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_q,
    output logic [31:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic [15:0] fetch_count
);

    logic [15:0] r_pc_f;
    logic        r_req_valid;
    logic [15:0] r_req_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic [31:0] r_if_id_instr;
    logic [15:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic [15:0] r_fetch_count;

    assign rom_addr    = r_pc_f;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f        <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_fetch_count <= 16'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= RESET_PC;
            r_if_id_valid <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over stall: anything in flight or skidded is dropped.
            r_pc_f        <= redirect_pc;
            r_req_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= redirect_pc;
            r_if_id_valid <= 1'b0;
        end else if (stall) begin
            // The word returning this cycle would be lost, so park it in the skid slot.
            r_req_valid <= 1'b0;
            if (r_req_valid) begin
                r_skid_instr <= rom_q;
                r_skid_pc    <= r_req_pc;
                r_skid_valid <= 1'b1;
            end
        end else begin
            r_pc_f      <= r_pc_f + 16'd1;
            r_req_valid <= 1'b1;
            r_req_pc    <= r_pc_f;
            if (r_skid_valid) begin
                r_if_id_instr <= r_skid_instr;
                r_if_id_pc    <= r_skid_pc;
                r_if_id_valid <= 1'b1;
                r_skid_valid  <= 1'b0;
                r_fetch_count <= r_fetch_count + 16'd1;
            end else if (r_req_valid) begin
                r_if_id_instr <= rom_q;
                r_if_id_pc    <= r_req_pc;
                r_if_id_valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 16'd1;
            end else begin
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 1-cycle ROM holding 32'h1000_0000+addr.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] rom_addr;
    logic [31:0] rom_q;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM: mem[i] = 32'h1000_0000 + i
    always @(posedge clk) rom_q <= 32'h1000_0000 + {16'd0, rom_addr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] pc, input logic vld);
        check_eq({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
        check_eq({tag, "_pc"}, {16'd0, if_id_pc}, {16'd0, pc});
        check_eq({tag, "_instr"}, if_id_instr, vld ? (32'h1000_0000 + {16'd0, pc}) : 32'h0);
    endtask

    // A pending request and a pending skid entry must never coexist.
    always @(negedge clk) begin
        if (!reset)
            check_eq("inv_req_skid", {31'd0, dut.r_req_valid & dut.r_skid_valid}, 32'd0);
    end

    logic [15:0] cnt0;

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        tick(); tick();
        check_ifid("rst", 16'h0000, 1'b0);
        check_eq("rst_count", {16'd0, fetch_count}, 32'd0);
        check_eq("rst_romaddr", {16'd0, rom_addr}, 32'd0);

        // Reset then run
        reset = 1'b0;
        tick();
        check_eq("run_bubble", {31'd0, if_id_valid}, 32'd0);
        check_eq("run_romaddr", {16'd0, rom_addr}, 32'd1);
        tick();
        check_ifid("run_pc0", 16'h0000, 1'b1);
        check_eq("run_count1", {16'd0, fetch_count}, 32'd1);
        for (int p = 1; p <= 3; p++) begin
            tick();
            check_ifid("run_seq", p[15:0], 1'b1);
            if (p == 2) check_eq("run_count3", {16'd0, fetch_count}, 32'd3);
        end
        tick(); tick();
        check_ifid("run_pc5", 16'h0005, 1'b1);

        // Single-cycle stall
        stall = 1'b1;
        tick();
        check_ifid("st1_hold", 16'h0005, 1'b1);
        stall = 1'b0;
        tick();
        check_ifid("st1_skid", 16'h0006, 1'b1);
        tick();
        check_ifid("st1_next", 16'h0007, 1'b1);
        check_eq("st1_count", {16'd0, fetch_count}, 32'd8);

        // Redirect back to 4 with latency check
        redirect = 1'b1; redirect_pc = 16'h0004;
        tick();
        check_ifid("rd_flush", 16'h0004, 1'b0);
        redirect = 1'b0;
        tick();
        check_ifid("rd_t1", 16'h0004, 1'b0);
        tick();
        check_ifid("rd_t2", 16'h0004, 1'b1);
        tick();
        check_ifid("rd_t3", 16'h0005, 1'b1);

        // Four-cycle stall
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_ifid("st4_hold", 16'h0005, 1'b1);
            check_eq("st4_romaddr", {16'd0, rom_addr}, 32'd7);
        end
        stall = 1'b0;
        tick();
        check_ifid("st4_rel6", 16'h0006, 1'b1);
        tick();
        check_ifid("st4_rel7", 16'h0007, 1'b1);
        tick();
        check_ifid("st4_rel8", 16'h0008, 1'b1);

        // Redirect and stall together: redirect wins, skid dropped
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        check_ifid("rdst_flush", 16'h0040, 1'b0);
        check_eq("rdst_skid", {31'd0, dut.r_skid_valid}, 32'd0);
        redirect = 1'b0;
        tick(); tick();
        check_ifid("rdst_hold", 16'h0040, 1'b0);
        stall = 1'b0;
        tick();
        check_ifid("rdst_t1", 16'h0040, 1'b0);
        tick();
        check_ifid("rdst_t2", 16'h0040, 1'b1);

        // Address wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        cnt0 = fetch_count;
        tick(); check_ifid("wrap_fffe", 16'hFFFE, 1'b1);
        tick(); check_ifid("wrap_ffff", 16'hFFFF, 1'b1);
        tick(); check_ifid("wrap_0000", 16'h0000, 1'b1);
        tick(); check_ifid("wrap_0001", 16'h0001, 1'b1);
        check_eq("wrap_count", {16'd0, fetch_count - cnt0}, 32'd4);

        // Reset during a stall with the skid full
        stall = 1'b1;
        tick();
        check_eq("rs_skid_full", {31'd0, dut.r_skid_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check_ifid("rs_out", 16'h0000, 1'b0);
        check_eq("rs_count", {16'd0, fetch_count}, 32'd0);
        check_eq("rs_romaddr", {16'd0, rom_addr}, 32'd0);
        check_eq("rs_skid", {31'd0, dut.r_skid_valid}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        tick();
        check_ifid("rs_t1", 16'h0000, 1'b0);
        tick();
        check_ifid("rs_t2", 16'h0000, 1'b1);
        check_eq("rs_count1", {16'd0, fetch_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
